// File: rtl/divider_8bit_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and the default operand width.
package divider_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_8bit_trial_subtractor.sv
// Combinational two's-complement subtractor (a + ~b + 1) used as the
// divider's per-cycle trial subtract. The result is split into its sign
// bit (negative flag) and the remaining magnitude bits.
module trial_subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-2:0] o_diff,
    output logic         o_neg
);

    logic [W-1:0] w_full;

    assign w_full          = i_a + ~i_b + W'(1);
    assign {o_neg, o_diff} = w_full;

endmodule

// File: rtl/divider_8bit.sv
// Sequential restoring divider: unsigned WIDTH-bit dividend / divisor,
// one quotient bit per clock, start/busy/done handshake.
module divider_8bit
    import divider_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_next;

    // The partial remainder is always < D after the restore step, so its
    // (WIDTH+1)-th bit is always zero and only WIDTH bits are kept.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_dbz;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_trial;
    logic             w_trial_neg;
    logic [WIDTH-1:0] w_rem_new;
    logic [WIDTH-1:0] w_q_new;
    logic             w_last;
    logic             w_div_zero;

    // One iteration step: shift {R,Q} left, trial subtract D, restore on borrow.
    assign w_rem_shift = {r_rem, r_q[WIDTH-1]};
    assign w_rem_new   = w_trial_neg ? w_rem_shift[WIDTH-1:0] : w_trial;
    assign w_q_new     = {r_q[WIDTH-2:0], ~w_trial_neg};
    assign w_last      = (r_count == CW'(WIDTH - 1));
    assign w_div_zero  = (divisor == '0);

    trial_subtractor #(
        .W (WIDTH + 1)
    ) u_trial (
        .i_a    (w_rem_shift),
        .i_b    ({1'b0, r_d}),
        .o_diff (w_trial),
        .o_neg  (w_trial_neg)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; DONE always lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand load, iteration, and result capture on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_count   <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            r_quot    <= '1;
                            r_rem_out <= dividend;
                            r_dbz     <= 1'b1;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= dividend;
                            r_d     <= divisor;
                            r_count <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_rem   <= w_rem_new;
                    r_q     <= w_q_new;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_quot    <= w_q_new;
                        r_rem_out <= w_rem_new;
                        r_dbz     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem_out;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_8bit.sv
// Self-checking bench for divider_8bit: directed vectors plus random
// operand pairs, checked against a cycle-level arithmetic model.
module tb_divider_8bit;

    localparam int WIDTH = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    divider_8bit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: an operation occupies WIDTH busy cycles then one done cycle;
    // results come straight from integer / and %.
    int m_busy_left = 0;
    bit m_done = 1'b0;
    int m_q = 0, m_r = 0;
    bit m_z = 1'b0;
    int p_q = 0, p_r = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy_left <= 0;
            m_done      <= 1'b0;
            m_q         <= 0;
            m_r         <= 0;
            m_z         <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_done) begin
                // back to idle
            end else if (m_busy_left > 0) begin
                m_busy_left <= m_busy_left - 1;
                if (m_busy_left == 1) begin
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_z    <= 1'b0;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    m_done <= 1'b1;
                    m_q    <= MAXV;
                    m_r    <= int'(dividend);
                    m_z    <= 1'b1;
                end else begin
                    m_busy_left <= WIDTH;
                    p_q         <= int'(dividend) / int'(divisor);
                    p_r         <= int'(dividend) % int'(divisor);
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cyc busy", int'(busy), int'(m_busy_left > 0));
        check("cyc done", int'(done), int'(m_done));
        check("cyc quotient", int'(quotient), m_q);
        check("cyc remainder", int'(remainder), m_r);
        check("cyc div_by_zero", int'(div_by_zero), int'(m_z));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic launch(input int a, input int b);
        @(negedge clk);
        start    = 1'b1;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        @(negedge clk);
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    // Waits (bounded) for done; returns negedges from start and busy samples.
    task automatic wait_done(input string nm, output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({nm, " done seen"}, int'(done), 1);
    endtask

    task automatic do_op(input int a, input int b, input int eq, input int er,
                         input int ez, input string nm);
        int lat, nbusy;
        launch(a, b);
        wait_done(nm, lat, nbusy);
        check({nm, " latency"}, lat, (b == 0) ? 1 : WIDTH + 1);
        check({nm, " busy cycles"}, nbusy, (b == 0) ? 0 : WIDTH);
        check({nm, " quotient"}, int'(quotient), eq);
        check({nm, " remainder"}, int'(remainder), er);
        check({nm, " div_by_zero"}, int'(div_by_zero), ez);
        check({nm, " model q"}, m_q, eq);
        check({nm, " model r"}, m_r, er);
        $display("op %0d / %0d -> q=%0d r=%0d z=%0d latency=%0d", a, b,
                 quotient, remainder, div_by_zero, lat);
        @(negedge clk);
        check({nm, " idle busy"}, int'(busy), 0);
        check({nm, " idle done"}, int'(done), 0);
    endtask

    initial begin
        int ndone, cq, cr, lat, nbusy, a, b;

        // Reset state
        @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst quotient", int'(quotient), 0);
        check("rst remainder", int'(remainder), 0);
        check("rst div_by_zero", int'(div_by_zero), 0);
        reset = 1'b1;
        @(negedge clk);

        do_op(9, 6, 1, 3, 0, "9/6");
        do_op(200, 7, 28, 4, 0, "200/7");
        do_op(5, 8, 0, 5, 0, "5/8");
        do_op(255, 1, 255, 0, 0, "255/1");
        do_op(37, 0, 255, 37, 1, "37/0");
        do_op(10, 3, 3, 1, 0, "10/3");
        do_op(255, 255, 1, 0, 0, "255/255");
        do_op(0, 13, 0, 0, 0, "0/13");

        // Start during RUN is ignored
        launch(50, 5);
        ndone = 0;
        cq = -1;
        cr = -1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin
                start    = 1'b1;
                dividend = WIDTH'(100);
                divisor  = WIDTH'(9);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                cq = int'(quotient);
                cr = int'(remainder);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore done pulses", ndone, 1);
        check("ignore quotient", cq, 10);
        check("ignore remainder", cr, 0);
        $display("op 50 / 5 with restart -> q=%0d r=%0d pulses=%0d", cq, cr, ndone);

        // Reset mid-operation
        launch(9, 6);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst quotient", int'(quotient), 0);
        check("midrst remainder", int'(remainder), 0);
        check("midrst div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst no done", ndone, 0);
        $display("op 9 / 6 abandoned by reset, done pulses after=%0d", ndone);
        do_op(9, 6, 1, 3, 0, "9/6 after reset");

        // Random operand pairs: invariant and latency
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(1, MAXV));
            launch(a, b);
            wait_done("rand", lat, nbusy);
            check("rand latency", lat, WIDTH + 1);
            check("rand invariant", int'(quotient) * b + int'(remainder), a);
            check("rand rem<div", int'(int'(remainder) < b), 1);
            $display("op %0d / %0d -> q=%0d r=%0d latency=%0d", a, b,
                     quotient, remainder, lat);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/divider_8bit.md
Name: divider_8bit

Overview:
- Sequential restoring divider: unsigned WIDTH-bit dividend / divisor to quotient and remainder, one quotient bit per clock.
- Consumes the arithmetic unit's two's-complement subtraction as its per-cycle trial subtract. It sits directly downstream of the 8-bit subtractor in the Arithmetic Circuits chain.
- Start/busy/done handshake to the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend, sampled with start.
- divisor  input  WIDTH  unsigned divisor, sampled with start.
- quotient  output  WIDTH  registered quotient of last completed operation.
- remainder  output  WIDTH  registered remainder of last completed operation.
- busy  output  1  high while iterating (RUN state).
- done  output  1  single-cycle completion pulse (DONE state).
- div_by_zero  output  1  registered flag, valid with done, held until the next completion.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; quotient, remainder, busy, done, div_by_zero, internal partial remainder, quotient shift register, divisor copy and iteration counter all 0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE, start=1, divisor!=0: load partial remainder R=0 (WIDTH+1 bits), Q=dividend, D=divisor, count=0. Next state is RUN.
- IDLE, start=1, divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1. Next state is DONE. No RUN cycles.
- IDLE, start=0: hold.
- RUN, each edge:
  - Shift {R,Q} left 1.
  - Trial T = R_shifted - {1'b0,D} in WIDTH+1 bits, two's complement.
  - If T MSB==0: R=T and Q[0]=1. Otherwise R is restored (kept as R_shifted) and Q[0]=0.
  - count++.
- On the WIDTH-th RUN edge: quotient and remainder are loaded from the final Q and R[WIDTH-1:0], div_by_zero=0, next state DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE unconditionally.
- Latency: with start sampled at edge k, done is high in the cycle following edge k+WIDTH (nonzero divisor) or edge k+1 (zero divisor).
- Throughput: one operation per WIDTH+2 cycles minimum.
- start while RUN or DONE: ignored, not queued. Operand inputs are don't-care outside the IDLE+start edge.
- quotient, remainder and div_by_zero hold their values until the next completion. They are never updated mid-iteration.
- Reset mid-operation: the operation is abandoned, all outputs return to 0 and no done pulse is issued.
- Result invariant: dividend == quotient*divisor + remainder and remainder < divisor, for every divisor != 0.
- Counter width is $clog2(WIDTH)+1. There is no wrap within an operation.

Decomposition:
- Shared include file holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One natural sub-module, trial_subtractor: a parameterised (WIDTH+1)-bit two's-complement subtractor (a + ~b + 1), purely combinational. It outputs difference and a negative flag and is instantiated once.
- FSM, datapath registers and counter stay in divider_8bit.

Test Plan:
- 9 / 6: start for 1 cycle -> busy for 8 cycles; then done=1 for 1 cycle with quotient=1, remainder=3, div_by_zero=0.
- 200 / 7 -> quotient=28, remainder=4. Then 5 / 8 -> quotient=0, remainder=5. Then 255 / 1 -> quotient=255, remainder=0. busy=0 between operations.
- 37 / 0 -> done one cycle after start, quotient=255, remainder=37, div_by_zero=1, busy never high. The following 10 / 3 -> quotient=3, remainder=1, div_by_zero=0.
- start re-asserted with 100 / 9 during RUN of 50 / 5 -> ignored; result quotient=10, remainder=0; exactly one done pulse.
- reset pulled low on RUN cycle 4 of 9 / 6 -> all outputs 0 at once, no done. Then 9 / 6 after release -> quotient=1, remainder=3.
- Random 1000 operand pairs with divisor != 0 -> invariant dividend == quotient*divisor + remainder and remainder < divisor holds; done latency always WIDTH+1 edges.
